// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: iterative radix-2 multiply / restoring divide sequencer that owns HI/LO.
// Optional MD_ZERO_SKIP_EN: zero-operand multiplies and divide-by-zero bypass the BUSY phase.
module md_unit_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mdopE,
  input  logic             mdrdE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo, opnd;
  logic             is_div, neg_res, neg_rem, div_zero;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic             op_mul, op_div, op_sgn, op_mt, start, mt_write, skip, busy_live;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    op_mul    = (mdopE == 3'd1) || (mdopE == 3'd2);
    op_div    = (mdopE == 3'd3) || (mdopE == 3'd4);
    op_sgn    = (mdopE == 3'd1) || (mdopE == 3'd3);
    op_mt     = (mdopE == 3'd5) || (mdopE == 3'd6);
    start     = (state == IDLE) && (op_mul || op_div) && !flushE;
    mt_write  = (state == IDLE) && op_mt && !flushE;
    busy_live = (state == BUSY) && !flushE;
    a_mag     = cond_neg(srcaE, op_sgn && srcaE[WIDTH-1]);
    b_mag     = cond_neg(srcbE, op_sgn && srcbE[WIDTH-1]);
  end

`ifdef MD_ZERO_SKIP_EN
  assign skip = start && ((op_mul && ((srcaE == '0) || (srcbE == '0))) ||
                          (op_div && (srcbE == '0)));
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = skip ? DONE : BUSY;
      BUSY:    if (flushE) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // MFHI/MFLO and MTHI/MTLO wait behind an in-flight operation; a flush releases the pipe at once.
  always_comb begin
    stall_o = 1'b0;
    if (rst_n) begin
      stall_o = start || busy_live || ((mdrdE || op_mt) && busy_live);
    end
  end

  assign busy_o = (state == BUSY);

  logic [WIDTH-1:0]   addend, step_lo, res_hi, res_lo;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff, step_hi;
  logic [2*WIDTH-1:0] prod;
  logic               div_ge;

  always_comb begin
    addend   = acc_lo[0] ? opnd : '0;
    mul_sum  = acc_hi + {1'b0, addend};
    div_sh   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ge   = !div_diff[WIDTH];
    if (is_div) begin
      step_hi = div_ge ? div_diff : div_sh;
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = {1'b0, mul_sum[WIDTH:1]};
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
    prod = cond_neg2({step_hi[WIDTH-1:0], step_lo}, neg_res);
    if (is_div) begin
      res_hi = cond_neg(step_hi[WIDTH-1:0], neg_rem);
      res_lo = div_zero ? '1 : cond_neg(step_lo, neg_res);
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Operands are held as magnitudes; signs are re-applied only when the result commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      cnt      <= CW'(WIDTH-1);
      acc_hi   <= '0;
      acc_lo   <= op_div ? a_mag : b_mag;
      opnd     <= op_div ? b_mag : a_mag;
      is_div   <= op_div;
      neg_res  <= op_sgn && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
      neg_rem  <= op_sgn && srcaE[WIDTH-1];
      div_zero <= op_div && (srcbE == '0);
    end else if (busy_live) begin
      cnt      <= cnt - CW'(1);
      acc_hi   <= step_hi;
      acc_lo   <= step_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (busy_live && (cnt == '0)) begin
      hi_o <= res_hi;
      lo_o <= res_lo;
    end else if (skip) begin
      hi_o <= op_div ? srcaE : '0;
      lo_o <= op_div ? '1 : '0;
    end else if (mt_write) begin
      if (mdopE == 3'd5) hi_o <= srcaE;
      else               lo_o <= srcaE;
    end
  end
endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed vector table, corner sequences, random ops vs model.
module tb_md_unit_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    mdopE;
  logic          mdrdE, flushE;
  logic [W-1:0]  srcaE, srcbE;
  logic          stall_o, busy_o;
  logic [W-1:0]  hi_o, lo_o;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] ref_hi, ref_lo;

  always #5 clk = ~clk;

  md_unit_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .mdopE(mdopE), .mdrdE(mdrdE), .flushE(flushE),
    .srcaE(srcaE), .srcbE(srcbE), .stall_o(stall_o), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_stall(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MD_ZERO_SKIP_EN
    if ((op <= 3'd2 && (a == 0 || b == 0)) || (op >= 3'd3 && b == 0)) return 1;
`endif
    return W + 1;
  endfunction

  // Reference: plain integer arithmetic on 64-bit values.
  task automatic ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] h, output logic [W-1:0] l);
    logic [63:0] p, q, r;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0; q = '0; r = '0;
    h = '0; l = '0;
    case (op)
      3'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      3'd3: if (b == 0) begin h = a; l = '1; end
            else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      3'd4: if (b == 0) begin h = a; l = '1; end
            else begin l = a / b; h = a % b; end
      default: ;
    endcase
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one MULT/DIV, count stall cycles, check HI/LO in DONE, then an MFHI in the next cycle.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    @(posedge clk); #1;
    mdopE = op; srcaE = a; srcbE = b; flushE = 1'b0; mdrdE = 1'b0;
    n = 0;
    @(negedge clk);
    while (stall_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({nm, ".stall_cycles"}, 64'(n), 64'(exp_stall(op, a, b)));
    check({nm, ".hi"}, {32'b0, hi_o}, {32'b0, eh});
    check({nm, ".lo"}, {32'b0, lo_o}, {32'b0, el});
    @(posedge clk); #1;
    mdopE = 3'd0; mdrdE = 1'b1;
    @(negedge clk);
    check({nm, ".mfhi_stall"}, {63'b0, stall_o}, 64'd0);
    check({nm, ".mfhi_val"}, {32'b0, hi_o}, {32'b0, eh});
    mdrdE = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] eh, el, a, b;
    logic [2:0]   op;
    logic         fl;
    int           n;

    vecs[0]  = '{3'd2, 32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd4, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[6]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{3'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[9]  = '{3'd4, 32'd100,       32'd3,         32'h0000_0001, 32'h0000_0021};
    vecs[10] = '{3'd1, 32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000};

    rst_n = 1'b0; mdopE = 3'd1; srcaE = 32'd3; srcbE = 32'd5; mdrdE = 1'b0; flushE = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.stall", {63'b0, stall_o}, 64'd0);
    check("reset.busy", {63'b0, busy_o}, 64'd0);
    check("reset.hi", {32'b0, hi_o}, 64'd0);
    check("reset.lo", {32'b0, lo_o}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mdopE = 3'd0;

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MTHI, then MULTU 2x2 with an MFHI arriving during BUSY
    @(posedge clk); #1;
    mdopE = 3'd5; srcaE = 32'h1234_5678;
    @(negedge clk);
    check("mthi.stall", {63'b0, stall_o}, 64'd0);
    @(posedge clk); #1;
    mdopE = 3'd2; srcaE = 32'd2; srcbE = 32'd2;
    @(negedge clk);
    check("mthi.hi", {32'b0, hi_o}, 64'h1234_5678);
    repeat (3) @(posedge clk);
    #1 mdrdE = 1'b1;
    n = 0;
    @(negedge clk);
    while (stall_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mfhi_busy.stall_cycles", 64'(n), 64'd30);
    check("mfhi_busy.busy", {63'b0, busy_o}, 64'd0);
    check("mfhi_busy.hi", {32'b0, hi_o}, 64'd0);
    check("mfhi_busy.lo", {32'b0, lo_o}, 64'd4);

    // Preload, start DIVU, flush mid-BUSY
    @(posedge clk); #1;
    mdrdE = 1'b0; mdopE = 3'd5; srcaE = 32'hAAAA;
    @(posedge clk); #1;
    mdopE = 3'd6; srcaE = 32'h5555;
    @(posedge clk); #1;
    mdopE = 3'd4; srcaE = 32'd100; srcbE = 32'd3;
    repeat (10) @(posedge clk);
    #1 flushE = 1'b1;
    @(negedge clk);
    check("flush.stall_drop", {63'b0, stall_o}, 64'd0);
    check("flush.busy_before", {63'b0, busy_o}, 64'd1);
    @(posedge clk); #1;
    flushE = 1'b0; mdopE = 3'd0;
    @(negedge clk);
    check("flush.busy_after", {63'b0, busy_o}, 64'd0);
    check("flush.hi", {32'b0, hi_o}, 64'hAAAA);
    check("flush.lo", {32'b0, lo_o}, 64'h5555);

    // Asynchronous reset in the middle of a MULT
    @(posedge clk); #1;
    mdopE = 3'd1; srcaE = 32'd5; srcbE = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    check("rstmid.busy_before", {63'b0, busy_o}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid.hi", {32'b0, hi_o}, 64'd0);
    check("rstmid.lo", {32'b0, lo_o}, 64'd0);
    check("rstmid.stall", {63'b0, stall_o}, 64'd0);
    check("rstmid.busy", {63'b0, busy_o}, 64'd0);
    mdopE = 3'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("post_reset", 3'd2, 32'd6, 32'd7, 32'd0, 32'd42);

    // Flushed ops in IDLE and the reserved opcode do nothing
    @(posedge clk); #1;
    mdopE = 3'd2; srcaE = 32'd9; srcbE = 32'd9; flushE = 1'b1;
    @(negedge clk);
    check("idle_flush.stall", {63'b0, stall_o}, 64'd0);
    @(posedge clk); #1;
    mdopE = 3'd5; srcaE = 32'hDEAD;
    @(negedge clk);
    check("idle_flush.busy", {63'b0, busy_o}, 64'd0);
    @(posedge clk); #1;
    mdopE = 3'd7; flushE = 1'b0;
    @(negedge clk);
    check("idle_flush.hi", {32'b0, hi_o}, 64'd0);
    check("idle_flush.lo", {32'b0, lo_o}, 64'd42);
    check("reserved.stall", {63'b0, stall_o}, 64'd0);
    @(posedge clk); #1;
    mdopE = 3'd0;
    @(negedge clk);
    check("reserved.busy", {63'b0, busy_o}, 64'd0);

    // Random operations against the reference model
    ref_hi = 32'd0; ref_lo = 32'd42;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = pick();
      b  = pick();
      if (op <= 3'd4) begin
        ref_op(op, a, b, eh, el);
        run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, eh, el);
        ref_hi = eh; ref_lo = el;
      end else begin
        fl = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        mdopE = op; srcaE = a; srcbE = b; flushE = fl;
        @(negedge clk);
        check($sformatf("rand%0d_mt.stall", i), {63'b0, stall_o}, 64'd0);
        if (!fl) begin
          if (op == 3'd5) ref_hi = a;
          else            ref_lo = a;
        end
        @(posedge clk); #1;
        mdopE = 3'd0; flushE = 1'b0;
        @(negedge clk);
        check($sformatf("rand%0d_mt.hi", i), {32'b0, hi_o}, {32'b0, ref_hi});
        check($sformatf("rand%0d_mt.lo", i), {32'b0, lo_o}, {32'b0, ref_lo});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Iterative multiply/divide sequencer attached beside the EX stage; owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a radix-2 shift-add multiplier or restoring divider for WIDTH cycles.
- Stalls the pipeline until the result is committed.
- Also stalls MFHI/MFLO reads issued while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width; also the BUSY iteration count.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- mdopE  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- mdrdE  input  1  MFHI/MFLO currently in EX
- flushE  input  1  EX instruction squashed this cycle
- srcaE  input  WIDTH  rs operand (multiplicand/dividend/MTHI-MTLO data)
- srcbE  input  WIDTH  rt operand (multiplier/divisor)
- stall_o  output  1  hold IF/ID/EX
- busy_o  output  1  state is BUSY
- hi_o  output  WIDTH  HI register
- lo_o  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n low): state IDLE, hi_o=0, lo_o=0, busy_o=0, iteration counter=0, operand/accumulator registers=0. stall_o=0 while in reset.
- States:
  - IDLE -> BUSY when mdopE is 1-4 and flushE=0: latch operand magnitudes, sign flags and op type; counter=WIDTH-1.
  - BUSY: one multiply/divide step per cycle; counter decrements. When counter=0, the next edge writes HI/LO and moves to DONE.
  - DONE -> IDLE unconditionally after one cycle.
- stall_o is combinational:
  - 1 in IDLE when mdopE is 1-4 and flushE=0;
  - 1 in BUSY;
  - 1 in IDLE or BUSY when mdrdE=1 or mdopE is 5/6 while busy.
  - Otherwise 0. It is always 0 in DONE.
- Latency: accept cycle + WIDTH BUSY cycles = WIDTH+1 stall cycles; the instruction leaves EX in the DONE cycle. HI/LO are valid from the DONE cycle.
- mdopE is ignored in DONE, since the same instruction is still in EX. A new operation is only accepted from IDLE.
- MTHI/MTLO: in IDLE with flushE=0, hi_o/lo_o <= srcaE at the edge. No stall, no state change.
- MULT/MULTU: 2*WIDTH product, HI=upper half, LO=lower half. Signed ops run on magnitudes; the product is negated when the operand signs differ.
- DIV/DIVU: LO=quotient, HI=remainder. Signed quotient truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero: LO=all ones, HI=dividend, with the same latency.
- Signed overflow (most-negative / -1): LO=most-negative, HI=0.
- flushE=1 in BUSY: abort; next state IDLE, HI/LO unchanged, stall_o drops the same cycle.
- flushE=1 in IDLE with mdopE 1-6: no accept, no write.
- rst_n low mid-BUSY: immediate return to reset values; a partial result is never written.
- mdrdE while IDLE or DONE: no stall; hi_o/lo_o reflect committed values. The DONE-cycle result is visible to a back-to-back MFHI in the following cycle.

Optional Feature:
- MD_ZERO_SKIP_EN defined:
  - On accept, if multiply has srcaE==0 or srcbE==0, or divide has srcbE==0, skip BUSY and go IDLE -> DONE.
  - Results are identical to the full run; stall is high for exactly 1 cycle.
- Undefined: every MULT/DIV runs the full WIDTH BUSY cycles.

Test Plan:
- MULTU 3 x 5 -> stall_o high 33 cycles, DONE on cycle 34, HI=0x00000000, LO=0x0000000F.
- MULT 0xFFFFFFFE x 3 (-2 x 3) -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; then MFHI next cycle sees 0xFFFFFFFF without stall.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007, stall 33 cycles; with MD_ZERO_SKIP_EN, stall 1 cycle and same result.
- MTHI 0x12345678, then MULTU 2 x 2 with MFHI issued during BUSY -> MFHI stalls until DONE, then reads 0x00000000, LO=0x00000004.
- Preload HI/LO via MTHI/MTLO to 0xAAAA/0x5555, start DIVU 100/3, assert flushE at BUSY cycle 10 -> stall_o drops immediately, state IDLE, HI/LO stay 0xAAAA/0x5555.
- Start MULT, pull rst_n low at BUSY cycle 5 -> hi_o=lo_o=0, stall_o=0, busy_o=0 asynchronously. After release, MULTU 6 x 7 gives LO=42.
